// File: rtl/instruction_decoder.sv
// RV32I/Zicsr instruction decoder with one-hot identifier output.
// Decode is combinational; all outputs are registered behind en.
module instruction_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_code,
   input  logic        en,
   output logic [31:0] invalid_instruction,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [47:0] inst_flags
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [47:0] flags_d;
   logic        use_rd;
   logic        use_rs1;
   logic        use_rs2;

   assign opcode = instruction_code[6:0];
   assign funct3 = instruction_code[14:12];
   assign funct7 = instruction_code[31:25];

   always_comb begin
      flags_d = '0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         7'b0110111: begin
            flags_d[0] = 1'b1;
            use_rd     = 1'b1;
         end
         7'b0010111: begin
            flags_d[1] = 1'b1;
            use_rd     = 1'b1;
         end
         7'b1101111: begin
            flags_d[2] = 1'b1;
            use_rd     = 1'b1;
         end
         7'b1100111: begin
            if (funct3 == 3'b000) begin
               flags_d[3] = 1'b1;
               use_rd     = 1'b1;
               use_rs1    = 1'b1;
            end
         end
         7'b1100011: begin
            case (funct3)
               3'b000:  flags_d[4] = 1'b1;
               3'b001:  flags_d[5] = 1'b1;
               3'b100:  flags_d[6] = 1'b1;
               3'b101:  flags_d[7] = 1'b1;
               3'b110:  flags_d[8] = 1'b1;
               3'b111:  flags_d[9] = 1'b1;
               default: ;
            endcase
            use_rs1 = |flags_d;
            use_rs2 = |flags_d;
         end
         7'b0000011: begin
            case (funct3)
               3'b000:  flags_d[10] = 1'b1;
               3'b001:  flags_d[11] = 1'b1;
               3'b010:  flags_d[12] = 1'b1;
               3'b100:  flags_d[13] = 1'b1;
               3'b101:  flags_d[14] = 1'b1;
               default: ;
            endcase
            use_rd  = |flags_d;
            use_rs1 = |flags_d;
         end
         7'b0100011: begin
            case (funct3)
               3'b000:  flags_d[15] = 1'b1;
               3'b001:  flags_d[16] = 1'b1;
               3'b010:  flags_d[17] = 1'b1;
               default: ;
            endcase
            use_rs1 = |flags_d;
            use_rs2 = |flags_d;
         end
         7'b0010011: begin
            case (funct3)
               3'b000: flags_d[18] = 1'b1;
               3'b010: flags_d[19] = 1'b1;
               3'b011: flags_d[20] = 1'b1;
               3'b100: flags_d[21] = 1'b1;
               3'b110: flags_d[22] = 1'b1;
               3'b111: flags_d[23] = 1'b1;
               3'b001: flags_d[24] = (funct7 == 7'b0000000);
               3'b101: begin
                  flags_d[25] = (funct7 == 7'b0000000);
                  flags_d[26] = (funct7 == 7'b0100000);
               end
               default: ;
            endcase
            use_rd  = |flags_d;
            use_rs1 = |flags_d;
         end
         7'b0110011: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  flags_d[27] = 1'b1;
                  3'b001:  flags_d[29] = 1'b1;
                  3'b010:  flags_d[30] = 1'b1;
                  3'b011:  flags_d[31] = 1'b1;
                  3'b100:  flags_d[32] = 1'b1;
                  3'b101:  flags_d[33] = 1'b1;
                  3'b110:  flags_d[35] = 1'b1;
                  default: flags_d[36] = 1'b1;
               endcase
            end else if (funct7 == 7'b0100000) begin
               flags_d[28] = (funct3 == 3'b000);
               flags_d[34] = (funct3 == 3'b101);
            end
            use_rd  = |flags_d;
            use_rs1 = |flags_d;
            use_rs2 = |flags_d;
         end
         7'b0001111: begin
            flags_d[37] = (funct3 == 3'b000);
         end
         7'b1110011: begin
            // Trap/return words carry no operands, so only CSR forms expose indices.
            case (funct3)
               3'b001: flags_d[40] = 1'b1;
               3'b010: flags_d[41] = 1'b1;
               3'b011: flags_d[42] = 1'b1;
               3'b101: flags_d[43] = 1'b1;
               3'b110: flags_d[44] = 1'b1;
               3'b111: flags_d[45] = 1'b1;
               default: ;
            endcase
            use_rd  = |flags_d;
            use_rs1 = |flags_d;
            flags_d[38] = (instruction_code == 32'h0000_0073);
            flags_d[39] = (instruction_code == 32'h0010_0073);
            flags_d[46] = (instruction_code == 32'h3020_0073);
         end
         7'b1111111: begin
            flags_d[47] = 1'b1;
            use_rd      = 1'b1;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         invalid_instruction <= '0;
         rd                  <= '0;
         rs1                 <= '0;
         rs2                 <= '0;
         inst_flags          <= '0;
      end else if (en) begin
         invalid_instruction <= (|flags_d) ? 32'h0 : 32'hFFFF_FFFF;
         rd                  <= use_rd  ? instruction_code[11:7]  : 5'd0;
         rs1                 <= use_rs1 ? instruction_code[19:15] : 5'd0;
         rs2                 <= use_rs2 ? instruction_code[24:20] : 5'd0;
         inst_flags          <= flags_d;
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: table-driven reference
// model, directed spec vectors, then randomized words.
module tb_instruction_decoder;

   typedef struct packed {
      logic [31:0] inv;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [47:0] flags;
   } out_t;

   typedef struct {
      logic [31:0] mask;
      logic [31:0] match;
      int          bitn;
      bit          ur;
      bit          u1;
      bit          u2;
   } pat_t;

   logic        clk = 0;
   logic        rst;
   logic        en;
   logic [31:0] instruction_code;
   logic [31:0] invalid_instruction;
   logic [4:0]  rd, rs1, rs2;
   logic [47:0] inst_flags;

   int   n_checks = 0;
   int   n_fail   = 0;
   out_t exp_q[$];
   out_t model_q;
   pat_t tbl[$];

   instruction_decoder dut (
      .clk                 (clk),
      .rst                 (rst),
      .instruction_code    (instruction_code),
      .en                  (en),
      .invalid_instruction (invalid_instruction),
      .rd                  (rd),
      .rs1                 (rs1),
      .rs2                 (rs2),
      .inst_flags          (inst_flags)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic [31:0] m, input logic [31:0] v,
                               input int b, input bit ur, input bit u1,
                               input bit u2);
      pat_t p;
      p.mask = m; p.match = v; p.bitn = b;
      p.ur = ur; p.u1 = u1; p.u2 = u2;
      tbl.push_back(p);
   endfunction

   function automatic logic [31:0] f3(input int f);
      return 32'(f) << 12;
   endfunction

   function automatic void build_table();
      int br_f3[6] = '{0, 1, 4, 5, 6, 7};
      int ld_f3[5] = '{0, 1, 2, 4, 5};
      int im_f3[6] = '{0, 2, 3, 4, 6, 7};
      int r_f3[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
      int r_bit[8] = '{27, 29, 30, 31, 32, 33, 35, 36};
      int cs_f3[6] = '{1, 2, 3, 5, 6, 7};
      add(32'h7F, 32'h37, 0, 1, 0, 0);
      add(32'h7F, 32'h17, 1, 1, 0, 0);
      add(32'h7F, 32'h6F, 2, 1, 0, 0);
      add(32'h707F, 32'h67, 3, 1, 1, 0);
      for (int i = 0; i < 6; i++) add(32'h707F, 32'h63 | f3(br_f3[i]), 4 + i, 0, 1, 1);
      for (int i = 0; i < 5; i++) add(32'h707F, 32'h03 | f3(ld_f3[i]), 10 + i, 1, 1, 0);
      for (int i = 0; i < 3; i++) add(32'h707F, 32'h23 | f3(i), 15 + i, 0, 1, 1);
      for (int i = 0; i < 6; i++) add(32'h707F, 32'h13 | f3(im_f3[i]), 18 + i, 1, 1, 0);
      add(32'hFE00707F, 32'h00001013, 24, 1, 1, 0);
      add(32'hFE00707F, 32'h00005013, 25, 1, 1, 0);
      add(32'hFE00707F, 32'h40005013, 26, 1, 1, 0);
      for (int i = 0; i < 8; i++) add(32'hFE00707F, 32'h33 | f3(r_f3[i]), r_bit[i], 1, 1, 1);
      add(32'hFE00707F, 32'h40000033, 28, 1, 1, 1);
      add(32'hFE00707F, 32'h40005033, 34, 1, 1, 1);
      add(32'h707F, 32'h0F, 37, 0, 0, 0);
      add(32'hFFFFFFFF, 32'h00000073, 38, 0, 0, 0);
      add(32'hFFFFFFFF, 32'h00100073, 39, 0, 0, 0);
      for (int i = 0; i < 6; i++) add(32'h707F, 32'h73 | f3(cs_f3[i]), 40 + i, 1, 1, 0);
      add(32'hFFFFFFFF, 32'h30200073, 46, 0, 0, 0);
      add(32'h7F, 32'h7F, 47, 1, 1, 1);
   endfunction

   function automatic out_t ref_decode(input logic [31:0] w);
      out_t o;
      o = '0;
      o.inv = 32'hFFFF_FFFF;
      foreach (tbl[i]) begin
         if ((w & tbl[i].mask) == tbl[i].match) begin
            o.inv = 32'h0;
            o.flags = 48'd1 << tbl[i].bitn;
            o.rd  = tbl[i].ur ? w[11:7]  : 5'd0;
            o.rs1 = tbl[i].u1 ? w[19:15] : 5'd0;
            o.rs2 = tbl[i].u2 ? w[24:20] : 5'd0;
         end
      end
      return o;
   endfunction

   // Drive one cycle; a forced expectation overrides the model for spec vectors.
   task automatic step(input logic [31:0] w, input logic e, input logic r,
                       input bit force_exp, input out_t fexp);
      @(negedge clk);
      instruction_code = w;
      en  = e;
      rst = r;
      if (r) model_q = '0;
      else if (e) model_q = force_exp ? fexp : ref_decode(w);
      exp_q.push_back(model_q);
   endtask

   function automatic out_t mk(input logic [47:0] f, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] inv);
      out_t o;
      o.flags = f; o.rd = d; o.rs1 = s1; o.rs2 = s2; o.inv = inv;
      return o;
   endfunction

   initial begin
      out_t got, ex;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            got = '{invalid_instruction, rd, rs1, rs2, inst_flags};
            n_checks++;
            if (got !== ex || $countones(inst_flags) > 1) begin
               n_fail++;
               $display("FAIL decode: got flags=%h rd=%0d rs1=%0d rs2=%0d inv=%h, expected flags=%h rd=%0d rs1=%0d rs2=%0d inv=%h",
                        got.flags, got.rd, got.rs1, got.rs2, got.inv,
                        ex.flags, ex.rd, ex.rs1, ex.rs2, ex.inv);
            end
         end
      end
   end

   initial begin
      logic [31:0] w;
      int k, sel, budget;
      build_table();
      rst = 1; en = 0; instruction_code = '0;
      model_q = '0;
      step(32'h0, 1'b1, 1'b1, 1, '0);
      step(32'h00000797, 1, 0, 1, mk(48'h2, 15, 0, 0, 0));
      step(32'h305793F3, 1, 0, 1, mk(48'h010000000000, 7, 15, 0, 0));
      step(32'h02C78793, 1, 0, 1, mk(48'h1 << 18, 15, 15, 0, 0));
      step(32'h00112623, 1, 0, 1, mk(48'h1 << 17, 0, 2, 1, 0));
      step(32'h04079263, 1, 0, 1, mk(48'h20, 0, 15, 0, 0));
      step(32'h30200073, 1, 0, 1, mk(48'h1 << 46, 0, 0, 0, 0));
      step(32'h8000007F, 1, 0, 1, mk(48'h1 << 47, 0, 0, 0, 0));
      step(32'h07F56513, 1, 0, 1, mk(48'h1 << 22, 10, 10, 0, 0));
      step(32'h00000000, 1, 0, 1, mk(48'h0, 0, 0, 0, 32'hFFFF_FFFF));
      step(32'h1A5000EF, 1, 0, 1, mk(48'h4, 1, 0, 0, 0));
      step(32'h00000000, 0, 0, 1, '0);
      step(32'h00000000, 0, 0, 1, '0);
      step(32'h1A5000EF, 1, 1, 1, '0);
      step(32'h1A5000EF, 0, 1, 1, '0);
      step(32'h00003003, 1, 0, 1, mk(48'h0, 0, 0, 0, 32'hFFFF_FFFF));
      step(32'h00002063, 1, 0, 1, mk(48'h0, 0, 0, 0, 32'hFFFF_FFFF));
      step(32'h20005013, 1, 0, 1, mk(48'h0, 0, 0, 0, 32'hFFFF_FFFF));
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 9);
         k   = $urandom_range(0, tbl.size() - 1);
         w   = ($urandom & ~tbl[k].mask) | tbl[k].match;
         if (sel < 3) w = w ^ (32'd1 << $urandom_range(0, 31));
         else if (sel == 3) w = $urandom;
         step(w, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 0, '0);
      end
      @(negedge clk);
      en = 0; rst = 0;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected outputs never observed, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 Port: clk  input  1  single clock; all outputs registered on its rising edge.
REQ-002 Port: rst  input  1  reset, synchronous and active-high.
REQ-003 Port: instruction_code  input  32  RV32 instruction word to decode.
REQ-004 Port: en  input  1  decode enable; output registers update only when high.
REQ-005 Port: invalid_instruction  output  32  32'hFFFFFFFF when the decoded word is unrecognised, otherwise 32'h0.
REQ-006 Port: rd  output  5  destination register index, or 0 when the format has no rd.
REQ-007 Port: rs1  output  5  source register 1 index (uimm for CSR immediate forms), or 0 when unused.
REQ-008 Port: rs2  output  5  source register 2 index, or 0 when unused.
REQ-009 Port: inst_flags  output  48  one-hot instruction identifier; all zero when invalid.

Function
REQ-010 Latency is one cycle: values sampled at edge N (en=1) appear on outputs after edge N; en=0 holds all outputs.
REQ-011 Flag bits: 0 lui, 1 auipc, 2 jal, 3 jalr, 4 beq, 5 bne, 6 blt, 7 bge, 8 bltu, 9 bgeu.
REQ-012 Flag bits: 10 lb, 11 lh, 12 lw, 13 lbu, 14 lhu, 15 sb, 16 sh, 17 sw.
REQ-013 Flag bits: 18 addi, 19 slti, 20 sltiu, 21 xori, 22 ori, 23 andi, 24 slli, 25 srli, 26 srai.
REQ-014 Flag bits: 27 add, 28 sub, 29 sll, 30 slt, 31 sltu, 32 xor, 33 srl, 34 sra, 35 or, 36 and.
REQ-015 Flag bits: 37 fence, 38 ecall, 39 ebreak, 40 csrrw, 41 csrrs, 42 csrrc, 43 csrrwi, 44 csrrsi, 45 csrrci, 46 mret, 47 custom.
REQ-016 Matching uses opcode[6:0], funct3[14:12], funct7[31:25] per RV32I/Zicsr; R-type requires funct7 = 0000000 (or 0100000 for sub/sra).
REQ-017 slli/srli require funct7 = 0000000; srai requires funct7 = 0100000; other funct7 values are invalid.
REQ-018 ecall, ebreak and mret match only exact words 32'h00000073, 32'h00100073, 32'h30200073.
REQ-019 fence matches opcode 0001111 with funct3 000; CSR ops match opcode 1110011 with funct3 001/010/011/101/110/111.
REQ-020 custom matches opcode 1111111 with any upper bits.
REQ-021 Undefined funct3 (e.g. load 011, branch 010) and any unmatched opcode yield flags 0 and invalid all-ones.
REQ-022 rd = instr[11:7] for U, J, I (jalr, loads, ALU-imm), R, CSR, custom; else 0.
REQ-023 rs1 = instr[19:15] for jalr, loads, stores, branches, ALU-imm, R, all CSR forms, custom; else 0.
REQ-024 rs2 = instr[24:20] for R, stores, branches, custom; else 0.
REQ-025 When invalid, rd, rs1 and rs2 are 0.
REQ-026 At most one inst_flags bit is ever set.

Reset
REQ-027 With rst high at a rising edge, all outputs go to 0 (invalid_instruction 32'h0), regardless of en.
REQ-028 rst has priority over en; decoding resumes on the first edge with rst low and en high.

Verification
REQ-029 Reset, then 32'h00000797 (en=1) -> inst_flags 48'h000000000002, rd=15, rs1=0, rs2=0, invalid 0.
REQ-030 32'h305793F3 -> inst_flags 48'h010000000000, rd=7, rs1=15, rs2=0; 32'h02C78793 -> bit 18, rd=15, rs1=15.
REQ-031 32'h00112623 -> bit 17, rs1=2, rs2=1, rd=0; 32'h04079263 -> bit 5, rs1=15, rs2=0.
REQ-032 32'h30200073 -> bit 46, all indices 0; 32'h8000007F -> bit 47; 32'h07F56513 -> bit 22, rd=10, rs1=10.
REQ-033 32'h00000000 -> inst_flags 0, invalid 32'hFFFFFFFF, indices 0.
REQ-034 Decode 32'h1A5000EF (bit 2, rd=1), then drop en and apply 32'h0 -> outputs unchanged; assert rst mid-stream -> all zero next edge.
